audiodac_fifo_feeder: RTL
=========================

# audiodac_fifo_feeder

Sample-stream transmitter for the `audiodac` FIFO input port. It buffers 16-bit audio samples from an on-chip valid/ready source and delivers them one at a time over the DAC's `fifo_i` / `fifo_rdy_i` / `fifo_ack_o` pins. Delivery uses a four-phase request/acknowledge handshake. The block sits between the sample source and the `audiodac` instance, or drives the shared `io_in` pins from the companion FPGA. The DAC status pins are synchronized locally, so the DAC may run on an unrelated clock.

## Interface
Parameters:
- `DW`, 16, sample width; matches the DAC `fifo_i` width.
- `DEPTH`, 8, local buffer entries; power of two, ≥2.
- `SYNC_STAGES`, 2, flops per synchronizer on `fifo_ack_i`, `fifo_full_i` and `fifo_empty_i`.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: block clock.
- `rst_i` in 1: synchronous active-high reset.
- `enable_i` in 1: allows new transfers to start.
- `s_dat_i` in DW: input sample.
- `s_valid_i` in 1: `s_dat_i` is valid.
- `s_ready_o` out 1: buffer can accept a sample.
- `fifo_o` out DW: sample to the DAC (drives `fifo_i`).
- `fifo_rdy_o` out 1: request to the DAC (drives `fifo_rdy_i`).
- `fifo_ack_i` in 1: acknowledge from the DAC (`fifo_ack_o`), asynchronous.
- `fifo_full_i` in 1: DAC FIFO full (`fifo_full_o`), asynchronous.
- `fifo_empty_i` in 1: DAC FIFO empty (`fifo_empty_o`), asynchronous.
- `level_o` out clog2(DEPTH)+1: local buffer occupancy.
- `busy_o` out 1: state machine is not in IDLE.
- `underrun_cnt_o` out 8: count of DAC underruns, saturating.

## Operation
**Local buffer**
- Circular buffer with DEPTH entries.
- Push when `s_valid_i & s_ready_o`.
- `s_ready_o` = (`level_o` != DEPTH) & !`rst_i`. A pop in the same cycle does not allow a push into a full buffer.
- Push and pop in the same cycle: the level is unchanged.
- Read and write pointers wrap modulo DEPTH.

**Synchronizers**
- `ack_s`, `full_s` and `empty_s` are the SYNC_STAGES-flop synchronized versions of the three DAC inputs.

**Handshake state machine**
- **IDLE**
  - Condition to leave: `enable_i` & `level_o`≠0 & !`full_s` & !`ack_s`.
  - When the condition holds: `fifo_o` ← buffer head, then go to SETUP.
- **SETUP**
  - Hold for 1 cycle so `fifo_o` settles before the request rises.
  - Set `fifo_rdy_o` ← 1, then go to REQ.
- **REQ**
  - Wait for `ack_s`=1.
  - On `ack_s`=1: pop the head, set `fifo_rdy_o` ← 0, then go to WAIT_LOW.
- **WAIT_LOW**
  - Wait for `ack_s`=0, then go to IDLE.

**Handshake rules**
- `fifo_o` is stable from SETUP entry until WAIT_LOW exit.
- `fifo_o` keeps its last value while in IDLE.
- `enable_i` low only prevents IDLE from starting a transfer. A transfer already in progress completes.
- `full_s` is checked only in IDLE. Once a request is raised it is never withdrawn before the acknowledge.
- The state machine has no timeout. An acknowledge that never comes holds REQ indefinitely; `busy_o` stays 1.

**Underrun counter**
- Increments on each rising edge of `empty_s` while `enable_i`=1.
- Saturates at 255.
- Cleared only by reset.

**Reset**
- A synchronous reset takes effect at any time, including mid-handshake.
- State ← IDLE; level, pointers and counter ← 0; synchronizer flops ← 0.
- Outputs: `fifo_o`=0, `fifo_rdy_o`=0, `busy_o`=0, `level_o`=0, `underrun_cnt_o`=0, `s_ready_o`=0 while `rst_i` is high.
- A sample being transferred when reset asserts is discarded.

## Timing
- Push accepted at edge N: `level_o`=1 after N.
  - `fifo_o` is valid after N+1.
  - `fifo_rdy_o` = 1 after N+2, given IDLE, enable and not full.
- `fifo_ack_i` rises before edge M (SYNC_STAGES=2):
  - `ack_s`=1 after M+1.
  - `fifo_rdy_o`=0 and the pop are registered at M+2.
- Falling `fifo_ack_i` reaches IDLE 3 edges later.
- The next SETUP starts 1 edge after IDLE at the earliest.
- Minimum transfer period with an instantly responding DAC: 8 cycles (SYNC_STAGES=2).
- All outputs are registered, except `s_ready_o`, which is a combinational decode of `level_o` and `rst_i`.

## Test plan
- **Single transfer:** after reset, push 0xA5C3, then the responder acknowledges 2 cycles after request.
  - Required: `fifo_o`=0xA5C3 one cycle before `fifo_rdy_o` rises.
  - Required: `fifo_rdy_o` falls 3 edges after the acknowledge.
  - Required: `level_o` returns to 0.
- **Buffer full:** push 9 samples 0x0001..0x0009 back-to-back with the DAC holding `fifo_full_i`=1.
  - Required: `s_ready_o`=0 after 8 pushes; 0x0009 is not accepted until a pop.
  - Required: no request is raised while full is asserted.
  - After `fifo_full_i` drops: the samples go out in order 0x0001..0x0008.
- **Wrap-around:** stream 20 samples with a randomized DAC acknowledge delay (0–10 cycles).
  - Required: all 20 arrive in order, with no duplicates or drops.
  - Required: `fifo_o` never changes while `fifo_rdy_o`=1.
- **Disable mid-transfer:** deassert `enable_i` during REQ.
  - Required: the current handshake completes.
  - Required: no new request while disabled, even with `level_o`=3.
  - Required: transfers resume after re-enable.
- **Reset mid-handshake:** assert `rst_i` in REQ with `fifo_ack_i`=1.
  - Required: `fifo_rdy_o`=0 and `level_o`=0 after the reset edge.
  - Required: after release, IDLE does not start a transfer until `ack_s`=0.
- **Underrun count:** toggle `fifo_empty_i` 0→1 260 times with enable=1, then 3 times with enable=0.
  - Required: `underrun_cnt_o`=255 and stays at 255.

Source files
------------

// File: rtl/audiodac_fifo_feeder.sv
// rtl/audiodac_fifo_feeder.sv - buffered four-phase request/acknowledge sample transmitter for the audiodac FIFO port
//
// Buffers DW-bit samples from a valid/ready source in a small circular buffer and hands them
// to the DAC one at a time using fifo_rdy_o / fifo_ack_i. The DAC status inputs are synchronized
// locally, so the DAC may run on an unrelated clock.
//
// Ports:
//   clk_i, rst_i          block clock, synchronous active-high reset
//   enable_i              allows new transfers to start (a running transfer always completes)
//   s_dat_i/s_valid_i     sample source; s_ready_o is high while the buffer has room
//   fifo_o/fifo_rdy_o     sample and request towards the DAC
//   fifo_ack_i            DAC acknowledge (asynchronous)
//   fifo_full_i           DAC FIFO full (asynchronous)
//   fifo_empty_i          DAC FIFO empty (asynchronous)
//   level_o               local buffer occupancy
//   busy_o                handshake state machine is not idle
//   underrun_cnt_o        saturating count of DAC underruns

module audiodac_fifo_feeder #(
  parameter int DW          = 16,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [DW-1:0]            s_dat_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [DW-1:0]            fifo_o,
  output logic                     fifo_rdy_o,
  input  logic                     fifo_ack_i,
  input  logic                     fifo_full_i,
  input  logic                     fifo_empty_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o,
  output logic [7:0]               underrun_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // ---------------------------------------------------------------------------
  // Synchronizers for the DAC status pins
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ack_sr;
  logic [SYNC_STAGES-1:0] full_sr;
  logic [SYNC_STAGES-1:0] empty_sr;
  logic                   ack_s;
  logic                   full_s;
  logic                   empty_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_sr   <= '0;
      full_sr  <= '0;
      empty_sr <= '0;
    end else begin
      ack_sr[0]   <= fifo_ack_i;
      full_sr[0]  <= fifo_full_i;
      empty_sr[0] <= fifo_empty_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ack_sr[i]   <= ack_sr[i-1];
        full_sr[i]  <= full_sr[i-1];
        empty_sr[i] <= empty_sr[i-1];
      end
    end
  end

  assign ack_s   = ack_sr[SYNC_STAGES-1];
  assign full_s  = full_sr[SYNC_STAGES-1];
  assign empty_s = empty_sr[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Local circular buffer
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Readiness depends only on the current level, so a pop in the same cycle
  // never opens a slot for a push into a full buffer.
  assign s_ready_o = (level_o != LW'(DEPTH)) && !rst_i;
  assign push      = s_valid_i && s_ready_o;

  // Storage needs no reset: push is forced low while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= s_dat_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ,
    WAIT_LOW
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] fifo_nxt;
  logic          rdy_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      fifo_o     <= '0;
      fifo_rdy_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_o     <= fifo_nxt;
      fifo_rdy_o <= rdy_nxt;
      busy_o     <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_nxt  = fifo_o;
    rdy_nxt   = fifo_rdy_o;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        // A still-high acknowledge (e.g. left over across a reset) must drop
        // before a new request may begin.
        if (enable_i && (level_o != '0) && !full_s && !ack_s) begin
          fifo_nxt  = mem[rd_ptr];
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        // fifo_o was loaded one cycle ago; raise the request now.
        rdy_nxt   = 1'b1;
        state_nxt = REQ;
      end
      REQ: begin
        if (ack_s) begin
          pop       = 1'b1;
          rdy_nxt   = 1'b0;
          state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!ack_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Underrun counter: rising edges of the synchronized empty flag
  // ---------------------------------------------------------------------------
  logic empty_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      empty_q        <= 1'b0;
      underrun_cnt_o <= '0;
    end else begin
      empty_q <= empty_s;
      if (empty_s && !empty_q && enable_i && (underrun_cnt_o != 8'hFF)) begin
        underrun_cnt_o <= underrun_cnt_o + 8'd1;
      end
    end
  end

endmodule
